// File: rtl/ysyx_23060059_wbu_if.sv
// LSU -> WBU result bundle: one valid pulse per instruction, no backpressure.
interface ysyx_23060059_wbu_if;
  logic        receive_valid;
  logic [31:0] wd_i;
  logic [31:0] csr_wd_i;
  logic [4:0]  rd_i;
  logic [1:0]  csr_rd_i;
  logic        reg_en_i;
  logic        csreg_en_i;
  logic [31:0] pc_i;
  logic [31:0] pc_next_i;
  logic [31:0] instruction_i;
  logic        ecall_i;
  logic        ebreak_i;
  logic        skip_d_i;

  modport master (
    output receive_valid, wd_i, csr_wd_i, rd_i, csr_rd_i, reg_en_i, csreg_en_i,
           pc_i, pc_next_i, instruction_i, ecall_i, ebreak_i, skip_d_i
  );

  modport slave (
    input receive_valid, wd_i, csr_wd_i, rd_i, csr_rd_i, reg_en_i, csreg_en_i,
          pc_i, pc_next_i, instruction_i, ecall_i, ebreak_i, skip_d_i
  );
endinterface

// File: rtl/ysyx_23060059_wbu.sv
// Write-back stage: stages one LSU bundle, commits it the following cycle, owns the
// GPR file and machine CSRs, and forwards the in-flight write to IDU read ports.
module ysyx_23060059_wbu #(
  parameter int unsigned CNT_W        = 64,
  parameter logic [31:0] MCAUSE_ECALL = 32'd11,
  parameter logic [31:0] MSTATUS_RST  = 32'h0000_1800
) (
  input  logic                 clock,
  input  logic                 reset,
  ysyx_23060059_wbu_if.slave   lsu,
  input  logic [4:0]           raddr1,
  input  logic [4:0]           raddr2,
  output logic [31:0]          rdata1,
  output logic [31:0]          rdata2,
  input  logic [1:0]           csr_raddr,
  output logic [31:0]          csr_rdata,
  output logic [31:0]          mtvec_o,
  output logic [31:0]          mepc_o,
  output logic                 commit_valid,
  output logic [31:0]          commit_pc,
  output logic [31:0]          commit_pc_next,
  output logic [31:0]          commit_inst,
  output logic                 commit_skip_d,
  output logic                 wbu_busy,
  output logic [4:0]           rd_wbu_to_idu,
  output logic                 halt,
  output logic [31:0]          halt_code,
  output logic [CNT_W-1:0]     retired_cnt
);

  typedef enum logic [0:0] {StIdle, StCommit} state_e;

  state_e            state_q;
  logic [31:0]       gpr_q [32];
  logic [31:0]       csr_q [4];
  logic [31:0]       wd_q, csr_wd_q, pc_q, pc_next_q, inst_q;
  logic [4:0]        rd_q;
  logic [1:0]        csr_rd_q;
  logic              reg_en_q, csreg_en_q, ecall_q, ebreak_q, skip_q;
  logic              halt_q;
  logic [31:0]       halt_code_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              commit, capture, gpr_wr;
  logic [31:0]       x10_fwd;

  assign commit  = (state_q == StCommit);
  assign capture = lsu.receive_valid && !halt_q;
  assign gpr_wr  = commit && reg_en_q && (rd_q != 5'd0);
  assign x10_fwd = (gpr_wr && rd_q == 5'd10) ? wd_q : gpr_q[10];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
      csr_q[0]    <= MSTATUS_RST;
      csr_q[1]    <= '0;
      csr_q[2]    <= '0;
      csr_q[3]    <= '0;
      wd_q        <= '0;
      csr_wd_q    <= '0;
      pc_q        <= '0;
      pc_next_q   <= '0;
      inst_q      <= '0;
      rd_q        <= '0;
      csr_rd_q    <= '0;
      reg_en_q    <= 1'b0;
      csreg_en_q  <= 1'b0;
      ecall_q     <= 1'b0;
      ebreak_q    <= 1'b0;
      skip_q      <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      cnt_q       <= '0;
    end else begin
      // A new capture and the current commit share this edge on back-to-back pulses.
      if (capture) begin
        state_q    <= StCommit;
        wd_q       <= lsu.wd_i;
        csr_wd_q   <= lsu.csr_wd_i;
        pc_q       <= lsu.pc_i;
        pc_next_q  <= lsu.pc_next_i;
        inst_q     <= lsu.instruction_i;
        rd_q       <= lsu.rd_i;
        csr_rd_q   <= lsu.csr_rd_i;
        reg_en_q   <= lsu.reg_en_i;
        csreg_en_q <= lsu.csreg_en_i;
        ecall_q    <= lsu.ecall_i;
        ebreak_q   <= lsu.ebreak_i;
        skip_q     <= lsu.skip_d_i;
      end else begin
        state_q <= StIdle;
      end
      if (commit) begin
        if (gpr_wr) gpr_q[rd_q] <= wd_q;
        if (csreg_en_q) csr_q[csr_rd_q] <= csr_wd_q;
        // Trap bookkeeping takes precedence over an explicit mepc/mcause write.
        if (ecall_q) begin
          csr_q[2] <= pc_q;
          csr_q[3] <= MCAUSE_ECALL;
        end
        if (ebreak_q) begin
          halt_q      <= 1'b1;
          halt_code_q <= x10_fwd;
        end
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rdata1 = gpr_q[raddr1];
    if (gpr_wr && rd_q == raddr1) rdata1 = wd_q;
    if (raddr1 == 5'd0) rdata1 = '0;
    rdata2 = gpr_q[raddr2];
    if (gpr_wr && rd_q == raddr2) rdata2 = wd_q;
    if (raddr2 == 5'd0) rdata2 = '0;
    csr_rdata = csr_q[csr_raddr];
    if (commit && csreg_en_q && csr_rd_q == csr_raddr) csr_rdata = csr_wd_q;
    if (commit && ecall_q && csr_raddr == 2'd2) csr_rdata = pc_q;
    if (commit && ecall_q && csr_raddr == 2'd3) csr_rdata = MCAUSE_ECALL;
  end

  assign mtvec_o        = csr_q[1];
  assign mepc_o         = csr_q[2];
  assign commit_valid   = commit;
  assign wbu_busy       = commit;
  assign commit_pc      = pc_q;
  assign commit_pc_next = pc_next_q;
  assign commit_inst    = inst_q;
  assign commit_skip_d  = skip_q;
  assign rd_wbu_to_idu  = (commit && reg_en_q) ? rd_q : 5'd0;
  assign halt           = halt_q;
  assign halt_code      = halt_code_q;
  assign retired_cnt    = cnt_q;

endmodule
